// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants and types used by the execute-stage units.
// Holds the register width, the M-extension divide opcode encoding,
// the divider FSM state type and a small magnitude helper.
package riscv_pkg;

  // Architectural register width (RV32 only).
  localparam int XLEN = 32;

  // Divide/remainder operation select as presented on req_op.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Most negative two's complement value; the only dividend that can overflow.
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's complement magnitude of v when neg is set, otherwise v unchanged.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? -v : v;
  endfunction

  // True for the signed flavours (DIV, REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU).
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// CALC cycle, followed by one sign-fixup cycle, so a normal result appears
// 33 cycles after the accepting edge. Divide-by-zero and signed overflow
// finish one cycle after accept.
// Optional feature: define DIV_EARLY_OUT_EN to also finish in one cycle
// whenever |divisor| > |dividend| (quotient 0, remainder = dividend).
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

  // Control state and registered handshake outputs.
  div_state_e       state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  result_q, result_d;

  // Datapath: quo_q starts as the dividend magnitude and is shifted left,
  // collecting quotient bits in the LSBs as the dividend bits leave the MSB.
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             fast_q, fast_d;
  logic [XLEN-1:0]  fast_res_q, fast_res_d;

  // Request decode, only meaningful on the accepting edge.
  logic             acc_signed;
  logic             acc_is_rem;
  logic             acc_a_neg;
  logic             acc_b_neg;
  logic [XLEN-1:0]  acc_a_mag;
  logic [XLEN-1:0]  acc_b_mag;
  logic             acc_div_zero;
  logic             acc_sig_ovf;
  logic             acc_early;
  logic             acc_fast;
  logic [XLEN-1:0]  acc_fast_res;

  // One restoring step and the final sign fixup.
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    trial;
  logic             trial_ok;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;

  // Decode the incoming request: magnitudes, signs and fast-path selection.
  always_comb begin
    acc_signed   = op_is_signed(req_op);
    acc_is_rem   = req_op[1];
    acc_a_neg    = acc_signed & req_a[XLEN-1];
    acc_b_neg    = acc_signed & req_b[XLEN-1];
    acc_a_mag    = magnitude(req_a, acc_a_neg);
    acc_b_mag    = magnitude(req_b, acc_b_neg);
    acc_div_zero = (req_b == '0);
    acc_sig_ovf  = acc_signed && (req_a == INT_MIN) && (req_b == '1);
`ifdef DIV_EARLY_OUT_EN
    acc_early    = !acc_div_zero && (acc_b_mag > acc_a_mag);
`else
    acc_early    = 1'b0;
`endif
    acc_fast     = acc_div_zero | acc_sig_ovf | acc_early;
    // Priority matters only for overlap: zero divisor wins over the rest.
    if (acc_div_zero) begin
      acc_fast_res = acc_is_rem ? req_a : '1;
    end else if (acc_sig_ovf) begin
      acc_fast_res = acc_is_rem ? '0 : INT_MIN;
    end else if (acc_early) begin
      acc_fast_res = acc_is_rem ? req_a : '0;
    end else begin
      acc_fast_res = '0;
    end
  end

  // Restoring step: shift in the next dividend bit and try the subtraction.
  always_comb begin
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    trial_ok  = ~trial[XLEN];
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  // Next-state logic for the FSM, handshakes and datapath; flush wins everywhere.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    divisor_d    = divisor_q;
    cnt_d        = cnt_q;
    is_rem_d     = is_rem_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    fast_d       = fast_q;
    fast_res_d   = fast_res_q;

    case (state_q)
      ST_IDLE: begin
        // A request arriving together with flush is dropped.
        if (req_valid && req_ready_q && !flush) begin
          state_d     = ST_CALC;
          req_ready_d = 1'b0;
          quo_d       = acc_a_mag;
          rem_d       = '0;
          divisor_d   = acc_b_mag;
          cnt_d       = '0;
          is_rem_d    = acc_is_rem;
          neg_quo_d   = acc_signed & (req_a[XLEN-1] ^ req_b[XLEN-1]);
          neg_rem_d   = acc_a_neg;
          fast_d      = acc_fast;
          fast_res_d  = acc_fast_res;
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else if (fast_q) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          result_d     = fast_res_q;
        end else if (cnt_q != LAST_CNT) begin
          rem_d = trial_ok ? trial : rem_shift;
          quo_d = {quo_q[XLEN-2:0], trial_ok};
          cnt_d = cnt_q + 1'b1;
        end else begin
          // All quotient bits are in; apply signs and publish.
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          result_d     = is_rem_q ? rem_fix : quo_fix;
        end
      end

      ST_DONE: begin
        // Result stays put until taken; new work only from the next IDLE cycle.
        if (flush || resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          result_d     = '0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        result_d     = '0;
      end
    endcase
  end

  // State registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      divisor_q    <= '0;
      cnt_q        <= '0;
      is_rem_q     <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      fast_q       <= 1'b0;
      fast_res_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      divisor_q    <= divisor_d;
      cnt_q        <= cnt_d;
      is_rem_q     <= is_rem_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      fast_q       <= fast_d;
      fast_res_q   <= fast_res_d;
    end
  end

  // result_q is only nonzero in DONE, so resp_data reads 0 whenever resp_valid is low.
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = result_q;

endmodule
